// File: rtl/multi_reload_counter.sv
// Bank of independent reloading up/down counters with a shared config write port.
// Each channel produces a registered terminal-count pulse and a one-shot done level.

module multi_reload_counter_ch #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             wr,
  input  logic [WIDTH-1:0] val,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done
);
  logic [WIDTH-1:0] reload_q;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] term;
  logic             at_term;

  // mode_q[0]: 1 = down, mode_q[1]: 1 = one-shot
  assign term    = mode_q[0] ? '0 : '1;
  assign at_term = (count == term);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reload_q <= '0;
      mode_q   <= '0;
      count    <= '0;
      done     <= 1'b0;
      tc       <= 1'b0;
    end else if (wr) begin
      reload_q <= val;
      mode_q   <= mode;
      count    <= val;
      done     <= 1'b0;
      tc       <= 1'b0;
    end else if (en && !done) begin
      if (at_term) begin
        tc <= 1'b1;
        // one-shot parks on the terminal value instead of reloading
        if (mode_q[1]) done  <= 1'b1;
        else           count <= reload_q;
      end else begin
        tc    <= 1'b0;
        count <= mode_q[0] ? count - 1'b1 : count + 1'b1;
      end
    end else begin
      tc <= 1'b0;
    end
  end
endmodule

module multi_reload_counter #(
  parameter  int WIDTH  = 8,
  parameter  int NUM_CH = 4,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic                    cfg_we_i,
  input  logic [CH_W-1:0]         cfg_ch_i,
  input  logic [WIDTH-1:0]        cfg_val_i,
  input  logic [1:0]              cfg_mode_i,
  output logic [NUM_CH*WIDTH-1:0] count_o,
  output logic [NUM_CH-1:0]       tc_o,
  output logic [NUM_CH-1:0]       done_o
);
  logic [NUM_CH-1:0][WIDTH-1:0] count;
  logic [NUM_CH-1:0]            wr;

  assign count_o = count;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    // out-of-range selects match no channel, so such writes are dropped
    assign wr[n] = cfg_we_i && (cfg_ch_i == CH_W'(n));

    multi_reload_counter_ch #(.WIDTH(WIDTH)) u_ch (
      .clk   (clk),
      .reset (reset),
      .en    (en_i[n]),
      .wr    (wr[n]),
      .val   (cfg_val_i),
      .mode  (cfg_mode_i),
      .count (count[n]),
      .tc    (tc_o[n]),
      .done  (done_o[n])
    );
  end
endmodule
